// File: rtl/pll_lock_reset_ce.sv
// PLL lock conditioner: synchronizes pll_locked, debounces it into core_reset and
// drives phase-aligned pixel/CPU clock enables. Optional lock-loss counter: PLL_LOCK_LOSS_COUNT_EN.
module pll_lock_reset_ce #(
  parameter int unsigned LOCK_STABLE_CYCLES = 4096,
  parameter int unsigned RESET_HOLD_CYCLES  = 16,
  parameter int unsigned CE_DIV_PIX         = 8,
  parameter int unsigned CE_DIV_CPU         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       core_reset,
  output logic       ce_pix,
  output logic       ce_cpu,
`ifdef PLL_LOCK_LOSS_COUNT_EN
  output logic [7:0] lock_loss_cnt,
`endif
  output logic       ready
);

  localparam int unsigned DIV_W = $clog2(CE_DIV_CPU);
  localparam int unsigned PIX_W = $clog2(CE_DIV_PIX);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, lk_s;
  logic [15:0]        stab_q, stab_d;
  logic [7:0]         hold_q, hold_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               core_reset_q, core_reset_d;
  logic               ce_pix_q, ce_pix_d;
  logic               ce_cpu_q, ce_cpu_d;
  logic               ready_q, ready_d;
  logic               active_d;
  logic               loss_s;
`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [7:0]         loss_q, loss_d;
`endif

  // Next-state, counters and registered-output values
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    hold_d  = hold_q;
    div_d   = div_q;
    loss_s  = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        div_d = '0;
        if (lk_s) begin
          state_d = STABLE;
          stab_d  = 16'd1;
        end else begin
          stab_d  = 16'd0;
        end
      end
      STABLE: begin
        div_d = '0;
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          stab_d  = 16'd0;
        end else if (stab_q == 16'(LOCK_STABLE_CYCLES)) begin
          state_d = HOLD;
          hold_d  = 8'd0;
        end else begin
          stab_d  = stab_q + 16'd1;
        end
      end
      HOLD, RUN: begin
        if (!lk_s) begin
          // Lock loss wins over a simultaneous soft_reset
          loss_s  = 1'b1;
          state_d = WAIT_LOCK;
          stab_d  = 16'd0;
          hold_d  = 8'd0;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
          if (soft_reset) begin
            state_d = HOLD;
            hold_d  = 8'd0;
          end else if (state_q == RUN) begin
            state_d = RUN;
          end else if (hold_q == 8'(RESET_HOLD_CYCLES - 1)) begin
            state_d = RUN;
          end else begin
            hold_d  = hold_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        stab_d  = 16'd0;
        hold_d  = 8'd0;
        div_d   = '0;
      end
    endcase

    // Enables fire on the edge after the divider shows all ones
    active_d     = (state_d == HOLD) || (state_d == RUN);
    ce_pix_d     = active_d && (&div_q[PIX_W-1:0]);
    ce_cpu_d     = active_d && (&div_q);
    core_reset_d = (state_d != RUN);
    ready_d      = (state_d == RUN);

`ifdef PLL_LOCK_LOSS_COUNT_EN
    if (loss_s && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end else begin
      loss_d = loss_q;
    end
`endif
  end

  // Synchronizer, FSM state, counters and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      lk_s         <= 1'b0;
      state_q      <= WAIT_LOCK;
      stab_q       <= 16'd0;
      hold_q       <= 8'd0;
      div_q        <= '0;
      core_reset_q <= 1'b1;
      ce_pix_q     <= 1'b0;
      ce_cpu_q     <= 1'b0;
      ready_q      <= 1'b0;
`ifdef PLL_LOCK_LOSS_COUNT_EN
      loss_q       <= 8'd0;
`endif
    end else begin
      sync1_q      <= pll_locked;
      lk_s         <= sync1_q;
      state_q      <= state_d;
      stab_q       <= stab_d;
      hold_q       <= hold_d;
      div_q        <= div_d;
      core_reset_q <= core_reset_d;
      ce_pix_q     <= ce_pix_d;
      ce_cpu_q     <= ce_cpu_d;
      ready_q      <= ready_d;
`ifdef PLL_LOCK_LOSS_COUNT_EN
      loss_q       <= loss_d;
`endif
    end
  end

  assign core_reset = core_reset_q;
  assign ce_pix     = ce_pix_q;
  assign ce_cpu     = ce_cpu_q;
  assign ready      = ready_q;
`ifdef PLL_LOCK_LOSS_COUNT_EN
  assign lock_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_reset_ce.sv
// Bench for pll_lock_reset_ce: directed scenarios plus randomized lock/soft-reset traffic,
// checked every cycle against an event-timing model (lock run length, hold age, entry age).
module tb_pll_lock_reset_ce;

  localparam int LSC = 8;
  localparam int RHC = 4;
  localparam int PIX = 8;
  localparam int CPU = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;
  logic soft_reset = 1'b0;
  logic core_reset, ce_pix, ce_cpu, ready;
`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  pll_lock_reset_ce #(
    .LOCK_STABLE_CYCLES(LSC),
    .RESET_HOLD_CYCLES (RHC),
    .CE_DIV_PIX        (PIX),
    .CE_DIV_CPU        (CPU)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .soft_reset(soft_reset),
    .core_reset(core_reset),
    .ce_pix    (ce_pix),
    .ce_cpu    (ce_cpu),
`ifdef PLL_LOCK_LOSS_COUNT_EN
    .lock_loss_cnt(lock_loss_cnt),
`endif
    .ready     (ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: the core is "active" once lk_s has been seen high LSC+1 edges in a row;
  // it runs once RHC edges have passed since the last hold start.
  bit m_s1, m_s2;
  int m_tlock, m_hold_age, m_entry_age, m_loss;
  bit m_active;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
  endtask

  task automatic model_edge(input bit lk, input bit sr, input bit r);
    bit lk_fsm, was_active;
    if (r) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_tlock = 0; m_active = 1'b0;
      m_hold_age = 0; m_entry_age = 0; m_loss = 0;
    end else begin
      lk_fsm = m_s2;
      m_s2 = m_s1;
      m_s1 = lk;
      was_active = m_active;
      if (!lk_fsm) begin
        if (was_active && m_loss < 255) m_loss++;
        m_tlock = 0;
        m_active = 1'b0;
      end else begin
        m_tlock++;
        if (!was_active && m_tlock == LSC + 1) begin
          m_active = 1'b1; m_entry_age = 0; m_hold_age = 0;
        end else if (was_active) begin
          m_entry_age++;
          if (sr) m_hold_age = 0;
          else m_hold_age++;
        end
      end
    end
  endtask

  task automatic cyc(input bit lk, input bit sr, input bit r);
    bit run;
    pll_locked = lk; soft_reset = sr; rst = r;
    @(posedge clk);
    model_edge(lk, sr, r);
    #1;
    run = m_active && (m_hold_age >= RHC);
    check("core_reset", core_reset, !run);
    check("ready", ready, run);
    check("ce_pix", ce_pix, m_active && m_entry_age > 0 && (m_entry_age % PIX) == 0);
    check("ce_cpu", ce_cpu, m_active && m_entry_age > 0 && (m_entry_age % CPU) == 0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
    check("lock_loss_cnt", lock_loss_cnt, m_loss);
`endif
  endtask

  initial begin
    int rel, n_pix, n_cpu, n_dbl, n_hi, rise, drop_left;
    bit prev_pix, lk;

    repeat (3) cyc(1'b0, 1'b0, 1'b1);

    // Power-up release edge
    rel = -1;
    for (int e = 0; e < 20; e++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (rel < 0 && !core_reset) rel = e;
    end
    check("release_edge", rel, 14);

    // CE cadence over 64 RUN cycles
    n_pix = 0; n_cpu = 0; n_dbl = 0; prev_pix = 1'b0;
    for (int i = 0; i < 64; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (ce_pix) n_pix++;
      if (ce_cpu) n_cpu++;
      if (ce_pix && prev_pix) n_dbl++;
      check("cpu_without_pix", ce_cpu & ~ce_pix, 1'b0);
      prev_pix = ce_pix;
    end
    check("pix_count", n_pix, 8);
    check("cpu_count", n_cpu, 4);
    check("pix_double", n_dbl, 0);

    // One-cycle soft reset in RUN
    n_hi = 0;
    cyc(1'b1, 1'b1, 1'b0);
    if (core_reset) n_hi++;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (core_reset) n_hi++;
    end
    check("soft_hold_len", n_hi, 4);

    // Lock loss in RUN
    rise = -1;
    for (int e = 1; e <= 6; e++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (rise < 0 && core_reset) rise = e;
    end
    check("loss_latency", rise, 3);
`ifdef PLL_LOCK_LOSS_COUNT_EN
    check("loss_cnt_one", lock_loss_cnt, 8'd1);
`endif

    // Bounce in STABLE: 5 counted cycles, 3 low, then re-lock
    repeat (7) cyc(1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    rel = -1;
    for (int e = 0; e < 20; e++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (rel < 0 && !core_reset) rel = e;
    end
    check("relock_release", rel, 14);

    // Simultaneous soft_reset and lock loss
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check("loss_beats_soft", {core_reset, ready}, 2'b10);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // rst mid-HOLD
    repeat (12) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    check("rst_outputs", {core_reset, ready, ce_pix, ce_cpu}, 4'b1000);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    // Randomized traffic
    drop_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (drop_left > 0) begin
        drop_left--; lk = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        drop_left = $urandom_range(0, 5); lk = 1'b0;
      end else begin
        lk = 1'b1;
      end
      cyc(lk, $urandom_range(0, 79) == 0, $urandom_range(0, 1499) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_reset_ce.md
Name: pll_lock_reset_ce

Overview:
- Sits directly downstream of the Galaga PLL wrapper and runs on its 48 MHz output.
- Converts the PLL's asynchronous `locked` into a clean, debounced core reset.
- Generates the phase-aligned pixel (6 MHz) and CPU (3 MHz) clock enables that the rest of the core uses instead of derived clocks.
- Tracks loss-of-lock and re-asserts reset safely, without glitching the enables.

Parameters:
- LOCK_STABLE_CYCLES, 4096: consecutive synchronized-locked cycles required before leaving reset; range 1..65535.
- RESET_HOLD_CYCLES, 16: cycles `core_reset` stays high with enables running, so enable-gated registers see reset; range 1..255.
- CE_DIV_PIX, 8: clk cycles per `ce_pix` pulse; power of two, ≥2.
- CE_DIV_CPU, 16: clk cycles per `ce_cpu` pulse; power of two, multiple of CE_DIV_PIX.

Ports:
- clk, in, 1: 48 MHz core clock (PLL outclk_0).
- rst, in, 1: synchronous, active-high reset.
- pll_locked, in, 1: PLL locked; asynchronous to clk.
- soft_reset, in, 1: synchronous request to re-run the reset hold (OSD/menu reset).
- core_reset, out, 1: active-high reset to the core.
- ce_pix, out, 1: one-cycle pixel clock enable.
- ce_cpu, out, 1: one-cycle CPU clock enable.
- ready, out, 1: high only in RUN.

Behaviour:
- Clocking and reset: one clock, `clk`. `rst` is synchronous and active-high.
- Values on `rst`:
  - state = WAIT_LOCK
  - both synchronizer flops = 0
  - all counters = 0
  - `core_reset` = 1, `ce_pix` = 0, `ce_cpu` = 0, `ready` = 0
- `rst` overrides every other input in the same cycle.
- Synchronizer: 2-flop on `pll_locked`, giving `lk_s`. Latency is 2 edges.
- All outputs are registered.
- WAIT_LOCK:
  - `core_reset` = 1; CE divider held at 0; CEs = 0.
  - `lk_s` = 1 → STABLE, with stable counter = 1.
- STABLE:
  - `lk_s` = 1: counter increments.
  - Counter reaching LOCK_STABLE_CYCLES → HOLD, with divider = 0 and hold counter = 0.
  - `lk_s` = 0 on any cycle → WAIT_LOCK, counter cleared.
- HOLD:
  - `core_reset` = 1; divider free-runs; hold counter increments each cycle.
  - Hold counter reaching RESET_HOLD_CYCLES-1 → RUN.
  - `soft_reset` = 1 clears the hold counter (restarts the hold).
- RUN:
  - `core_reset` = 0, `ready` = 1.
  - `soft_reset` = 1 → HOLD with hold counter = 0. `core_reset` rises on the next edge; the divider keeps running with no phase reset.
- Loss of lock: `lk_s` = 0 in HOLD or RUN → WAIT_LOCK. On the next edge, `core_reset` = 1, `ready` = 0, and the divider clears.
  - Loss of lock has priority over a simultaneous `soft_reset`.
- Divider: single counter of width log2(CE_DIV_CPU), wrapping.
  - `ce_pix` = 1 when the low log2(CE_DIV_PIX) bits are all ones.
  - `ce_cpu` = 1 when the whole counter is all ones.
  - Every `ce_cpu` pulse therefore coincides with a `ce_pix` pulse.
  - First `ce_pix` occurs CE_DIV_PIX cycles after entering HOLD.
- Release timing: `core_reset` falls exactly 2 + LOCK_STABLE_CYCLES + RESET_HOLD_CYCLES edges after the first edge sampling `pll_locked` = 1, provided lock is held throughout.
- Glitch rule: any `pll_locked` low pulse longer than one clk must restart the full sequence. Shorter pulses may be missed.

Optional Feature:
- Macro: PLL_LOCK_LOSS_COUNT_EN.
- Defined:
  - Adds output `lock_loss_cnt`, out, 8: saturating count of HOLD/RUN→WAIT_LOCK transitions.
  - Cleared only by `rst`; sticks at 255.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
All scenarios use LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4, CE_DIV_PIX=8, CE_DIV_CPU=16.
- Power-up: `rst` high for 3 cycles, then `pll_locked` held 1 from edge 0 → `core_reset` = 1 through edge 13, falls at edge 14; `ready` rises at edge 14.
- CE cadence in RUN, 64 cycles → `ce_pix` pulses every 8 cycles (8 total), `ce_cpu` every 16 (4 total), each `ce_cpu` coincident with a `ce_pix`, never two-cycle-wide.
- Lock bounce in STABLE: `pll_locked` low for 3 cycles after 5 stable cycles → returns to WAIT_LOCK; release occurs 14 edges after lock re-rises.
- Lock loss in RUN: `pll_locked` low → `core_reset` high and `ready` low 3 edges later, CEs stop. With macro on, `lock_loss_cnt` goes 0→1.
- `soft_reset` pulse (1 cycle) in RUN → `core_reset` high for exactly 4 cycles; `ce_pix` spacing unchanged across the event.
- Simultaneous `soft_reset` and lock loss in RUN → WAIT_LOCK taken, divider cleared; `rst` mid-HOLD returns all outputs to reset values on the next edge.
